// File: rtl/if_stage_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the default PC width, the squash
// instruction word and the default IF/ID bundle layout.
package if_pkg;

    localparam int PC_W_DEF = 12;

    // addi x0,x0,0 : harmless filler placed in IF/ID when it is squashed
    localparam logic [31:0] NOP_INST_DEF = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [PC_W_DEF-1:0] pc4;
        logic [31:0]         inst;
        logic                valid;
    } ifid_t;

endpackage

// File: rtl/if_stage_ctrl_if.sv
// Bus bundle between the fetch stage and its surroundings (hazard unit,
// instruction memory and the ID stage). The stage side uses 'master'.
// Optional macro IF_FLUSH_CNT_EN adds the flush_cnt_o event counter.
interface if_stage_ctrl_if
    import if_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            flush_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic            stall_i;
    logic [31:0]     imem_rdata_i;
    logic [PC_W-1:0] imem_addr_o;
    logic [PC_W-1:0] id_pc_o;
    logic [PC_W-1:0] id_pc4_o;
    logic [31:0]     id_inst_o;
    logic            id_valid_o;
    logic [31:0]     num_inst_o;
`ifdef IF_FLUSH_CNT_EN
    logic [15:0]     flush_cnt_o;
`endif

    modport master (
        input  flush_i, redirect_pc_i, stall_i, imem_rdata_i,
`ifdef IF_FLUSH_CNT_EN
        output flush_cnt_o,
`endif
        output imem_addr_o, id_pc_o, id_pc4_o, id_inst_o, id_valid_o, num_inst_o
    );

    modport slave (
        output flush_i, redirect_pc_i, stall_i, imem_rdata_i,
`ifdef IF_FLUSH_CNT_EN
        input  flush_cnt_o,
`endif
        input  imem_addr_o, id_pc_o, id_pc4_o, id_inst_o, id_valid_o, num_inst_o
    );

endinterface

// File: rtl/if_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register. Loads a full bundle, holds, or squashes the
// instruction to NOP while keeping the PC fields of the previous entry.
module if_id_reg
    import if_pkg::*;
#(
    parameter type         T        = ifid_t,
    parameter T            RST_VAL  = '0,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_load,
    input  logic i_squash,
    input  T     i_d,
    output T     o_q
);

    T r_q;

    // Bundle register: squash takes priority over a load; otherwise hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= RST_VAL;
        end else if (i_squash) begin
            r_q.inst  <= NOP_INST;
            r_q.valid <= 1'b0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC register, BOOT/RUN/FLUSH control FSM,
// fetched-instruction counter and the IF/ID register instance.
// Optional macro IF_FLUSH_CNT_EN adds a saturating count of accepted flushes.
module if_stage_ctrl
    import if_pkg::*;
#(
    parameter int              PC_W          = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              FLUSH_BUBBLES = 1,
    parameter logic [31:0]     NOP_INST      = NOP_INST_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    if_stage_ctrl_if.master bus
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc4;
        logic [31:0]     inst;
        logic            valid;
    } bundle_t;

    localparam bundle_t IFID_RST = '{pc: '0, pc4: PC_W'(4), inst: NOP_INST, valid: 1'b0};
    localparam logic [1:0] BUBBLE_RELOAD = 2'(FLUSH_BUBBLES - 1);

    state_t          r_state, w_nextState;
    logic [PC_W-1:0] r_pc, w_nextPc, w_pcPlus4, w_redirectPc;
    logic [1:0]      r_bubbleCnt, w_nextBubbleCnt;
    logic [31:0]     r_numInst;
    logic            w_load, w_squash;
    bundle_t         w_ifidD, w_ifidQ;

    assign w_pcPlus4    = r_pc + PC_W'(4);
    assign w_redirectPc = {bus.redirect_pc_i[PC_W-1:2], 2'b00};
    assign w_ifidD      = '{pc: r_pc, pc4: w_pcPlus4, inst: bus.imem_rdata_i, valid: 1'b1};

    // Next-state, next-PC and IF/ID control; flush outranks stall in RUN
    always_comb begin
        w_nextState     = r_state;
        w_nextPc        = r_pc;
        w_nextBubbleCnt = r_bubbleCnt;
        w_load          = 1'b0;
        w_squash        = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (bus.flush_i) begin
                    w_nextPc        = w_redirectPc;
                    w_squash        = 1'b1;
                    w_nextBubbleCnt = BUBBLE_RELOAD;
                    w_nextState     = (FLUSH_BUBBLES > 1) ? FLUSH : RUN;
                end else if (!bus.stall_i) begin
                    w_load   = 1'b1;
                    w_nextPc = w_pcPlus4;
                end
            end
            FLUSH: begin
                w_squash = 1'b1;
                if (bus.flush_i) begin
                    w_nextPc        = w_redirectPc;
                    w_nextBubbleCnt = BUBBLE_RELOAD;
                end else begin
                    w_nextBubbleCnt = (r_bubbleCnt == 2'd0) ? 2'd0 : r_bubbleCnt - 2'd1;
                    if (r_bubbleCnt <= 2'd1) begin
                        w_nextState = RUN;
                    end
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // State, PC and bubble counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_bubbleCnt <= 2'd0;
        end else begin
            r_state     <= w_nextState;
            r_pc        <= w_nextPc;
            r_bubbleCnt <= w_nextBubbleCnt;
        end
    end

    // Saturating count of real instructions entering IF/ID
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_numInst <= '0;
        end else if (w_load && (r_numInst != 32'hFFFF_FFFF)) begin
            r_numInst <= r_numInst + 32'd1;
        end
    end

`ifdef IF_FLUSH_CNT_EN
    logic [15:0] r_flushCnt;
    logic        w_flushAccepted;

    assign w_flushAccepted = bus.flush_i && ((r_state == RUN) || (r_state == FLUSH));

    // Saturating count of flush requests acted upon
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_flushCnt <= '0;
        end else if (w_flushAccepted && (r_flushCnt != 16'hFFFF)) begin
            r_flushCnt <= r_flushCnt + 16'd1;
        end
    end

    assign bus.flush_cnt_o = r_flushCnt;
`endif

    if_id_reg #(
        .T        (bundle_t),
        .RST_VAL  (IFID_RST),
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_load),
        .i_squash (w_squash),
        .i_d      (w_ifidD),
        .o_q      (w_ifidQ)
    );

    assign bus.imem_addr_o = r_pc;
    assign bus.id_pc_o     = w_ifidQ.pc;
    assign bus.id_pc4_o    = w_ifidQ.pc4;
    assign bus.id_inst_o   = w_ifidQ.inst;
    assign bus.id_valid_o  = w_ifidQ.valid;
    assign bus.num_inst_o  = r_numInst;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Scoreboard bench for if_stage_ctrl (FLUSH_BUBBLES = 2). Each stimulus
// step queues the outputs expected after the next rising edge; a monitor
// pops and compares one entry per falling edge.
module tb_if_stage_ctrl;

    localparam int          PC_W = 12;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef struct {
        int          stepNo;
        logic [11:0] addr;
        logic [11:0] idPc;
        logic [11:0] idPc4;
        logic [31:0] idInst;
        logic        idValid;
        logic [31:0] numInst;
    } expect_t;

    logic    clk  = 1'b0;
    logic    rstn = 1'b1;
    expect_t expQ[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      stepCount  = 0;

    if_stage_ctrl_if #(.PC_W(PC_W)) bus ();

    if_stage_ctrl #(
        .PC_W          (PC_W),
        .RESET_PC      (12'h000),
        .FLUSH_BUBBLES (2),
        .NOP_INST      (NOP)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word encodes its own address
    function automatic logic [31:0] memInst(input logic [11:0] a);
        return 32'hC0DE0000 | {20'h0, a};
    endfunction

    assign bus.imem_rdata_i = memInst(bus.imem_addr_o);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".addr"},  32'(bus.imem_addr_o), 32'h000);
        checkOutput({tag, ".idPc"},  32'(bus.id_pc_o),     32'h000);
        checkOutput({tag, ".idPc4"}, 32'(bus.id_pc4_o),    32'h004);
        checkOutput({tag, ".inst"},  bus.id_inst_o,        NOP);
        checkOutput({tag, ".valid"}, 32'(bus.id_valid_o),  32'h0);
        checkOutput({tag, ".num"},   bus.num_inst_o,       32'h0);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic applyStimulus(input logic f, input logic s, input logic [11:0] redir,
                                 input logic [11:0] eAddr, input logic [11:0] eIdPc,
                                 input logic eValid, input logic [31:0] eNum);
        expect_t e;
        bus.flush_i       = f;
        bus.stall_i       = s;
        bus.redirect_pc_i = redir;
        stepCount++;
        e.stepNo  = stepCount;
        e.addr    = eAddr;
        e.idPc    = eIdPc;
        e.idPc4   = eIdPc + 12'd4;
        e.idInst  = eValid ? memInst(eIdPc) : NOP;
        e.idValid = eValid;
        e.numInst = eNum;
        expQ.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("s%0d.addr", e.stepNo),  32'(bus.imem_addr_o), 32'(e.addr));
                checkOutput($sformatf("s%0d.idPc", e.stepNo),  32'(bus.id_pc_o),     32'(e.idPc));
                checkOutput($sformatf("s%0d.idPc4", e.stepNo), 32'(bus.id_pc4_o),    32'(e.idPc4));
                checkOutput($sformatf("s%0d.inst", e.stepNo),  bus.id_inst_o,        e.idInst);
                checkOutput($sformatf("s%0d.valid", e.stepNo), 32'(bus.id_valid_o),  32'(e.idValid));
                checkOutput($sformatf("s%0d.num", e.stepNo),   bus.num_inst_o,       e.numInst);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.flush_i       = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_pc_i = 12'h000;
        #2 rstn = 1'b0;
        #1 checkReset("rst0");
        @(negedge clk);
        #1 rstn = 1'b1;
        checkOutput("bootAddr", 32'(bus.imem_addr_o), 32'h000);

        //            flush stall redir   addr     idPc     v     num
        applyStimulus(0, 0, 12'h000, 12'h000, 12'h000, 1'b0, 32'd0);   // BOOT edge
        applyStimulus(0, 0, 12'h000, 12'h004, 12'h000, 1'b1, 32'd1);
        applyStimulus(0, 0, 12'h000, 12'h008, 12'h004, 1'b1, 32'd2);
        applyStimulus(0, 0, 12'h000, 12'h00C, 12'h008, 1'b1, 32'd3);
        applyStimulus(0, 0, 12'h000, 12'h010, 12'h00C, 1'b1, 32'd4);
        // flush at PC 010 to 100, two bubbles
        applyStimulus(1, 0, 12'h100, 12'h100, 12'h00C, 1'b0, 32'd4);
        applyStimulus(0, 0, 12'h000, 12'h100, 12'h00C, 1'b0, 32'd4);
        applyStimulus(0, 0, 12'h000, 12'h104, 12'h100, 1'b1, 32'd5);
        // redirect with low bits set lands on 01C
        applyStimulus(1, 0, 12'h01F, 12'h01C, 12'h100, 1'b0, 32'd5);
        applyStimulus(0, 0, 12'h000, 12'h01C, 12'h100, 1'b0, 32'd5);
        applyStimulus(0, 0, 12'h000, 12'h020, 12'h01C, 1'b1, 32'd6);
        // three stall cycles at PC 020
        applyStimulus(0, 1, 12'h000, 12'h020, 12'h01C, 1'b1, 32'd6);
        applyStimulus(0, 1, 12'h000, 12'h020, 12'h01C, 1'b1, 32'd6);
        applyStimulus(0, 1, 12'h000, 12'h020, 12'h01C, 1'b1, 32'd6);
        applyStimulus(0, 0, 12'h000, 12'h024, 12'h020, 1'b1, 32'd7);
        // get to 040, then flush and stall together
        applyStimulus(1, 0, 12'h040, 12'h040, 12'h020, 1'b0, 32'd7);
        applyStimulus(0, 0, 12'h000, 12'h040, 12'h020, 1'b0, 32'd7);
        applyStimulus(1, 1, 12'h0A0, 12'h0A0, 12'h020, 1'b0, 32'd7);
        applyStimulus(0, 1, 12'h000, 12'h0A0, 12'h020, 1'b0, 32'd7);
        applyStimulus(0, 0, 12'h000, 12'h0A4, 12'h0A0, 1'b1, 32'd8);
        // flush during FLUSH restarts with the new target
        applyStimulus(1, 0, 12'h200, 12'h200, 12'h0A0, 1'b0, 32'd8);
        applyStimulus(1, 0, 12'h300, 12'h300, 12'h0A0, 1'b0, 32'd8);
        applyStimulus(0, 0, 12'h000, 12'h300, 12'h0A0, 1'b0, 32'd8);
        applyStimulus(0, 0, 12'h000, 12'h304, 12'h300, 1'b1, 32'd9);
        // PC wrap from FFC
        applyStimulus(1, 0, 12'hFFC, 12'hFFC, 12'h300, 1'b0, 32'd9);
        applyStimulus(0, 0, 12'h000, 12'hFFC, 12'h300, 1'b0, 32'd9);
        applyStimulus(0, 0, 12'h000, 12'h000, 12'hFFC, 1'b1, 32'd10);
        applyStimulus(0, 0, 12'h000, 12'h004, 12'h000, 1'b1, 32'd11);
        // enter FLUSH, then reset asynchronously mid-cycle
        applyStimulus(1, 0, 12'h400, 12'h400, 12'h000, 1'b0, 32'd11);
`ifdef IF_FLUSH_CNT_EN
        checkOutput("flushCnt", 32'(bus.flush_cnt_o), 32'd8);
`endif
        bus.flush_i = 1'b0;
        #1 rstn = 1'b0;
        #1 checkReset("rstFlush");
`ifdef IF_FLUSH_CNT_EN
        checkOutput("flushCntRst", 32'(bus.flush_cnt_o), 32'd0);
`endif
        @(negedge clk);
        #1 rstn = 1'b1;
        // flush during BOOT is ignored
        applyStimulus(1, 0, 12'h800, 12'h000, 12'h000, 1'b0, 32'd0);
        applyStimulus(0, 0, 12'h000, 12'h004, 12'h000, 1'b1, 32'd1);

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
Instruction-fetch stage for the 5-stage core. Owns the PC register and the IF/ID pipeline register. Consumes the control-hazard flush (`flush_i`) and redirect target from the downstream hazard unit. Produces the PC/PC+4/instruction bundle for ID and the fetched-instruction count fed back to the hazard logic.

Parameters:
- PC_W, 12: PC and instruction-memory address width.
- RESET_PC, 12'h000: PC value loaded while reset is asserted.
- FLUSH_BUBBLES, 1: cycles of squashed IF/ID after a redirect; legal range 1..3.
- NOP_INST, 32'h00000013: instruction word (addi x0,x0,0) driven into IF/ID on a squash.

Ports:
- clk, in, 1: rising-edge clock.
- rstn, in, 1: asynchronous, active-low reset.
- flush_i, in, 1: control-hazard flush request from the hazard unit.
- redirect_pc_i, in, PC_W: correct next PC, valid when `flush_i`=1.
- stall_i, in, 1: data-hazard stall; freezes the PC and IF/ID.
- imem_rdata_i, in, 32: instruction word; combinational read of `imem_addr_o` in the same cycle.
- imem_addr_o, out, PC_W: fetch address (equals the PC register).
- id_pc_o, out, PC_W: PC of the instruction in IF/ID.
- id_pc4_o, out, PC_W: `id_pc_o`+4, modulo 2^PC_W.
- id_inst_o, out, 32: instruction in IF/ID.
- id_valid_o, out, 1: IF/ID holds a real instruction.
- num_inst_o, out, 32: count of valid instructions loaded into IF/ID.

Behaviour:
Reset (rstn=0, asynchronous) forces:
- PC = RESET_PC, state = BOOT, bubble counter = 0.
- id_pc_o = 0, id_pc4_o = 4, id_inst_o = NOP_INST, id_valid_o = 0, num_inst_o = 0.

FSM states: BOOT, RUN, FLUSH.
- BOOT: exactly one cycle after reset release. IF/ID stays invalid, PC holds. Next state is RUN. `flush_i` and `stall_i` are ignored in BOOT.
- RUN, no flush and no stall:
  - IF/ID loads {PC, PC+4, imem_rdata_i, valid=1}.
  - PC <= PC+4.
  - num_inst increments.
- RUN with stall_i=1 and flush_i=0: PC, IF/ID and num_inst all hold.
- RUN with flush_i=1, regardless of stall_i (flush has priority):
  - PC <= redirect_pc_i.
  - IF/ID loads NOP_INST with valid=0; id_pc_o and id_pc4_o hold.
  - Bubble counter <= FLUSH_BUBBLES-1.
  - Next state is FLUSH if FLUSH_BUBBLES>1, otherwise RUN.
- FLUSH:
  - IF/ID stays invalid (NOP_INST), PC holds, bubble counter decrements.
  - Return to RUN when the counter reaches 0.
  - flush_i=1 in FLUSH restarts the redirect with the new target and reloads the counter.
  - stall_i does not extend FLUSH.

Arithmetic and boundary rules:
- PC arithmetic is modulo 2^PC_W; 12'hFFC+4 wraps to 12'h000 with no error.
- num_inst saturates at 32'hFFFFFFFF.
- redirect_pc_i bits [1:0] are forced to 0 when loaded.
- Latency: an instruction fetched at cycle n is visible on the id_* outputs at cycle n+1.
- Reset asserted mid-FLUSH or mid-stall restores all reset values immediately.

Optional Feature:
IF_FLUSH_CNT_EN
- Defined: adds output `flush_cnt_o`[15:0], counting accepted flush_i events in RUN or FLUSH. It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package `if_pkg`:
  - state enum {BOOT, RUN, FLUSH};
  - NOP_INST constant;
  - PC_W default;
  - IF/ID bundle typedef {pc, pc4, inst, valid}.
- One sub-module, `if_id_reg`: the bundle register with load/hold/squash controls and asynchronous active-low reset. The FSM, PC and counters stay in the top.

Test Plan:
- Reset release, no stall or flush for 4 cycles:
  - imem_addr_o reads 000, 000, 004, 008, 00C;
  - id_valid_o rises one cycle after BOOT;
  - num_inst_o = 3.
- In RUN at PC=12'h010, flush_i=1 with redirect_pc_i=12'h100 and FLUSH_BUBBLES=2:
  - id_valid_o = 0 for 2 cycles and id_inst_o = 32'h00000013;
  - then imem_addr_o = 100 and id_pc_o = 100.
- stall_i=1 for 3 cycles at PC=12'h020: imem_addr_o, id_* and num_inst_o are frozen; fetch resumes at 020.
- flush_i and stall_i both high at PC=12'h040 with target 12'h0A0: the flush wins and the next fetch address is 0A0.
- Start at PC=12'hFFC with no hazards:
  - next imem_addr_o = 000;
  - id_pc4_o for the FFC instruction = 000.
- Assert rstn=0 during FLUSH: outputs return to reset values asynchronously, before the next clock edge; BOOT follows release.
